// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory controller.
// Holds the byte/address widths, the access-length encodings, the
// read/write direction, the client select and the controller state
// encodings. len_to_bytes() maps a length code to a byte count.
package mem_ctrl_pkg;

  localparam int unsigned ByteLen = 8;
  localparam int unsigned AddrLen = 32;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  typedef enum logic {
    Read  = 1'b0,
    Write = 1'b1
  } dir_e;

  typedef enum logic {
    WHO_IF  = 1'b0,
    WHO_MEM = 1'b1
  } who_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The 2'b11 code is treated as a word access.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: RAM bus plus the IF and MEM client ports of mem_ctrl.
//   RAM:  mem_din (RAM -> ctrl), mem_dout, mem_a, mem_wr (ctrl -> RAM)
//   IF:   if_req_i, if_addr_i -> ctrl; if_done_o, if_data_o <- ctrl
//   MEM:  mem_req_i, mem_wr_i, mem_addr_i, mem_len_i, mem_wdata_i -> ctrl;
//         mem_done_o, mem_rdata_o <- ctrl
// slave is the controller view, master the pipeline/RAM view.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_LEN = AddrLen
);

  logic [ByteLen-1:0]  mem_din;
  logic [ByteLen-1:0]  mem_dout;
  logic [ADDR_LEN-1:0] mem_a;
  logic                mem_wr;

  logic                if_req_i;
  logic [ADDR_LEN-1:0] if_addr_i;
  logic                if_done_o;
  logic [31:0]         if_data_o;

  logic                mem_req_i;
  logic                mem_wr_i;
  logic [ADDR_LEN-1:0] mem_addr_i;
  logic [1:0]          mem_len_i;
  logic [31:0]         mem_wdata_i;
  logic                mem_done_o;
  logic [31:0]         mem_rdata_o;

  modport slave (
    input  mem_din,
    output mem_dout, mem_a, mem_wr,
    input  if_req_i, if_addr_i,
    output if_done_o, if_data_o,
    input  mem_req_i, mem_wr_i, mem_addr_i, mem_len_i, mem_wdata_i,
    output mem_done_o, mem_rdata_o
  );

  modport master (
    output mem_din,
    input  mem_dout, mem_a, mem_wr,
    output if_req_i, if_addr_i,
    input  if_done_o, if_data_o,
    output mem_req_i, mem_wr_i, mem_addr_i, mem_len_i, mem_wdata_i,
    input  mem_done_o, mem_rdata_o
  );

endinterface

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: MEM-over-IF priority select with the accepted request
// latched on load.
//   sel_any/sel_dir/sel_addr/sel_byte0: combinational view of the winner,
//   used to issue the first byte on the accept edge.
//   who/dir/addr/nbytes/wdata: registered copy of the accepted request.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_LEN = AddrLen
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                load,
  input  logic                if_req_i,
  input  logic [ADDR_LEN-1:0] if_addr_i,
  input  logic                mem_req_i,
  input  logic                mem_wr_i,
  input  logic [ADDR_LEN-1:0] mem_addr_i,
  input  logic [1:0]          mem_len_i,
  input  logic [31:0]         mem_wdata_i,
  output logic                sel_any,
  output dir_e                sel_dir,
  output logic [ADDR_LEN-1:0] sel_addr,
  output logic [ByteLen-1:0]  sel_byte0,
  output who_e                who,
  output dir_e                dir,
  output logic [ADDR_LEN-1:0] addr,
  output logic [2:0]          nbytes,
  output logic [31:0]         wdata
);

  who_e        sel_who;
  logic [2:0]  sel_nbytes;
  logic [31:0] sel_wdata;

  always_comb begin
    sel_who    = WHO_IF;
    sel_dir    = Read;
    sel_addr   = if_addr_i;
    sel_nbytes = 3'd4;
    sel_wdata  = '0;
    if (mem_req_i) begin
      sel_who    = WHO_MEM;
      sel_dir    = mem_wr_i ? Write : Read;
      sel_addr   = mem_addr_i;
      sel_nbytes = len_to_bytes(mem_len_i);
      sel_wdata  = mem_wdata_i;
    end
  end

  assign sel_any   = if_req_i | mem_req_i;
  assign sel_byte0 = sel_wdata[ByteLen-1:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      who    <= WHO_IF;
      dir    <= Read;
      addr   <= '0;
      nbytes <= '0;
      wdata  <= '0;
    end else if (load) begin
      who    <= sel_who;
      dir    <= sel_dir;
      addr   <= sel_addr;
      nbytes <= sel_nbytes;
      wdata  <= sel_wdata;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises IF fetches and MEM loads/stores into little-endian
// byte transfers on a byte-wide RAM with one cycle of read latency.
//   clk_in  clock, rst_in synchronous active-high reset
//   rdy_in  0 freezes all state and forces mem_wr low
//   bus     mem_ctrl_if.slave: RAM port plus both client handshakes
// Read data is zero-extended; done/data outputs are registered pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_LEN = AddrLen,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  mem_ctrl_if.slave bus
);

  state_e state, state_d;

  // cnt counts enabled BUSY cycles from 1: during a read, bytes issue while
  // cnt < nbytes and byte (cnt-1-RD_LAT) is on mem_din for capture.
  logic [2:0]          cnt;
  logic [1:0]          lane;
  logic [31:0]         rbuf, cap_buf;
  logic [ADDR_LEN-1:0] mem_a_q;
  logic [ByteLen-1:0]  mem_dout_q;
  logic                mem_wr_q;
  logic                if_done_q, mem_done_q;
  logic [31:0]         if_data_q, mem_rdata_q;

  logic accept, issue, capture, finish;

  logic                sel_any;
  dir_e                sel_dir;
  logic [ADDR_LEN-1:0] sel_addr;
  logic [ByteLen-1:0]  sel_byte0;
  who_e                who;
  dir_e                dir;
  logic [ADDR_LEN-1:0] addr;
  logic [2:0]          nbytes;
  logic [31:0]         wdata;

  mem_ctrl_arb #(.ADDR_LEN(ADDR_LEN)) u_arb (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load        (accept & rdy_in),
    .if_req_i    (bus.if_req_i),
    .if_addr_i   (bus.if_addr_i),
    .mem_req_i   (bus.mem_req_i),
    .mem_wr_i    (bus.mem_wr_i),
    .mem_addr_i  (bus.mem_addr_i),
    .mem_len_i   (bus.mem_len_i),
    .mem_wdata_i (bus.mem_wdata_i),
    .sel_any     (sel_any),
    .sel_dir     (sel_dir),
    .sel_addr    (sel_addr),
    .sel_byte0   (sel_byte0),
    .who         (who),
    .dir         (dir),
    .addr        (addr),
    .nbytes      (nbytes),
    .wdata       (wdata)
  );

  assign lane = cnt[1:0] - 2'(RD_LAT) - 2'd1;

  always_comb begin
    cap_buf = rbuf;
    cap_buf[{lane, 3'b000} +: ByteLen] = bus.mem_din;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sel_any) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        issue = cnt < nbytes;
        if (dir == Read) begin
          capture = cnt > 3'(RD_LAT);
          finish  = cnt == nbytes + 3'(RD_LAT);
        end else begin
          finish = !issue;
        end
        if (finish) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rbuf        <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else if (rdy_in) begin
      state      <= state_d;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if (accept) begin
        cnt      <= 3'd1;
        rbuf     <= '0;
        mem_a_q  <= sel_addr;
        mem_wr_q <= (sel_dir == Write);
        if (sel_dir == Write) mem_dout_q <= sel_byte0;
      end
      if (state == ST_BUSY) cnt <= cnt + 3'd1;
      if (issue) begin
        mem_a_q <= addr + ADDR_LEN'(cnt);
        if (dir == Write) mem_dout_q <= wdata[{cnt[1:0], 3'b000} +: ByteLen];
      end
      if (capture) rbuf <= cap_buf;
      if (finish) begin
        mem_wr_q <= 1'b0;
        if (who == WHO_MEM) begin
          mem_done_q <= 1'b1;
          if (dir == Read) mem_rdata_q <= cap_buf;
        end else begin
          if_done_q <= 1'b1;
          if_data_q <= cap_buf;
        end
      end
    end
  end

  // While frozen mid-read, re-present the address of the byte still waiting
  // to be captured so the RAM has it on mem_din again when rdy_in returns.
  assign bus.mem_a = (!rdy_in && state == ST_BUSY && dir == Read && cnt > 3'(RD_LAT))
                     ? addr + ADDR_LEN'(lane) : mem_a_q;
  assign bus.mem_wr      = mem_wr_q & rdy_in;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.mem_done_o  = mem_done_q;
  assign bus.mem_rdata_o = mem_rdata_q;

endmodule
